// File: rtl/draw_pkg.sv
// Shared types and constants for the draw scheduler: screen geometry, field
// widths, colour key default and the scheduler state encoding.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 8;
    localparam int TIMER_W  = 16;
    localparam int GID_W    = 2;

    localparam logic [X_W-1:0]      SCREEN_W           = 8'd160;
    localparam logic [Y_W-1:0]      SCREEN_H           = 7'd120;
    localparam logic [COLOUR_W-1:0] COLOUR_KEY_DEFAULT = 8'hE3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT    = 3'd2,
        S_RELEASE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < SCREEN_W) && (y < SCREEN_H);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector for the sprite clients (indices 1..NUM_REQ-1).
// Bit 0 of req is never eligible; the pointer names the first client to look at.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        grant  = '0;
        ptr_nx = ptr;
        idx    = 0;
        // Scan farthest-first so the client nearest the pointer overwrites the rest.
        for (int k = NUM_REQ - 2; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
            if (req[idx[PTR_W-1:0]]) begin
                grant                 = '0;
                grant[idx[PTR_W-1:0]] = 1'b1;
                ptr_nx                = (idx + 1 >= NUM_REQ) ? PTR_W'(1) : PTR_W'(idx + 1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= PTR_W'(1);
        end else if (advance && |grant) begin
            ptr <= ptr_nx;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Grants one drawer at a time access to the VGA pixel port: client 0 first,
// sprites round-robin, with a hang watchdog and clip/colour-key filtering.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int                   NUM_REQ    = 4,
    parameter logic [COLOUR_W-1:0]  COLOUR_KEY = COLOUR_KEY_DEFAULT,
    parameter int                   TIMEOUT    = 40000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_REQ-1:0]           req,
    output logic [NUM_REQ-1:0]           ack,
    output logic [NUM_REQ-1:0]           drawStart,
    input  logic [NUM_REQ-1:0]           drawDone,
    input  logic [NUM_REQ*X_W-1:0]       drawX,
    input  logic [NUM_REQ*Y_W-1:0]       drawY,
    input  logic [NUM_REQ*COLOUR_W-1:0]  drawColour,
    input  logic [NUM_REQ-1:0]           drawWe,
    output logic [X_W-1:0]               vgaX,
    output logic [Y_W-1:0]               vgaY,
    output logic [COLOUR_W-1:0]          vgaColour,
    output logic                         vgaPlot,
    output logic                         busy,
    output logic [GID_W-1:0]             grantId,
    output logic                         timeoutErr
);

    state_t               state, state_nx;
    logic [TIMER_W-1:0]   timer;
    logic [NUM_REQ-1:0]   sprite_req, rr_grant;
    logic                 rr_advance, win_valid;
    logic [GID_W-1:0]     win_id;
    logic                 done_g, timer_expired, forward;
    logic [X_W-1:0]       px_x;
    logic [Y_W-1:0]       px_y;
    logic [COLOUR_W-1:0]  px_c;
    logic                 px_we;

    assign sprite_req = {req[NUM_REQ-1:1], 1'b0};
    assign rr_advance = (state == S_IDLE) && !req[0] && |sprite_req;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .resetn  (resetn),
        .req     (sprite_req),
        .advance (rr_advance),
        .grant   (rr_grant)
    );

    always_comb begin
        win_valid = |req;
        win_id    = '0;
        if (!req[0]) begin
            for (int i = 1; i < NUM_REQ; i++) begin
                if (rr_grant[i]) win_id = GID_W'(i);
            end
        end
    end

    // Only the granted client's pixel fields reach the output stage.
    always_comb begin
        px_x  = '0;
        px_y  = '0;
        px_c  = '0;
        px_we = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantId == GID_W'(i)) begin
                px_x  = drawX[i*X_W +: X_W];
                px_y  = drawY[i*Y_W +: Y_W];
                px_c  = drawColour[i*COLOUR_W +: COLOUR_W];
                px_we = drawWe[i];
            end
        end
    end

    assign done_g        = drawDone[grantId];
    assign timer_expired = (timer == TIMER_W'(TIMEOUT - 1));
    assign forward       = (state == S_START) || (state == S_WAIT);
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        drawStart = '0;
        ack       = '0;
        unique case (state)
            S_IDLE: begin
                if (win_valid) state_nx = S_START;
            end
            S_START: begin
                drawStart[grantId] = 1'b1;
                state_nx           = S_WAIT;
            end
            S_WAIT: begin
                drawStart[grantId] = 1'b1;
                if (done_g || timer_expired) state_nx = S_RELEASE;
            end
            S_RELEASE: begin
                ack[grantId] = 1'b1;
                state_nx     = S_DRAIN;
            end
            S_DRAIN: begin
                // A drawer still holding done would otherwise satisfy its next grant instantly.
                if (!done_g) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            grantId    <= '0;
            timer      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == S_IDLE && win_valid) grantId <= win_id;
            if (state == S_START) timer <= '0;
            if (state == S_WAIT) begin
                timer <= timer + TIMER_W'(1);
                if (!done_g && timer_expired) timeoutErr <= 1'b1;
            end
        end
    end

    // Coordinates follow the granted drawer even when the pixel is clipped or keyed.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            vgaX      <= '0;
            vgaY      <= '0;
            vgaColour <= '0;
            vgaPlot   <= 1'b0;
        end else if (forward) begin
            vgaX      <= px_x;
            vgaY      <= px_y;
            vgaColour <= px_c;
            vgaPlot   <= px_we && on_screen(px_x, px_y)
                         && !((grantId != '0) && (px_c == COLOUR_KEY));
        end else begin
            vgaPlot   <= 1'b0;
        end
    end

endmodule
